// File: rtl/discharge_param_scheduler.sv
// Start/stop arbitration and shadowed Ton/Toff/Ip/waveform updates for the discharge core;
// parameters reach the core only when stopped, at a pulse boundary, or after a drain.
//   state   | meaning
//   IDLE    | stopped, pending shadows commit immediately
//   RUN     | discharging, Ton/Toff/Ip commit on cycle_boundary
//   DRAIN   | waveform change pending, waiting for core_idle
//   RESTART | waveform committed, re-enabling the core
module discharge_param_scheduler #(
  parameter logic [15:0] DEF_TON       = 16'd500,
  parameter logic [15:0] DEF_TOFF      = 16'd2000,
  parameter logic [15:0] DEF_IP        = 16'd20,
  parameter logic [15:0] DEF_WAVE      = 16'h2001,
  parameter logic [15:0] TON_MIN       = 16'd50,
  parameter logic [15:0] TON_MAX       = 16'd30000,
  parameter logic [15:0] TOFF_MIN      = 16'd300,
  parameter logic [15:0] IP_MAX        = 16'd120,
  parameter logic [15:0] DRAIN_TIMEOUT = 16'd20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        machine_start_ack_spi,
  input  logic        machine_start_ack_key,
  input  logic        machine_stop_ack_spi,
  input  logic        machine_stop_ack_key,
  input  logic        change_Ton_ack,
  input  logic        change_Toff_ack,
  input  logic        change_Ip_ack,
  input  logic        change_waveform_ack,
  input  logic [15:0] Ton_data_async,
  input  logic [15:0] Toff_data_async,
  input  logic [15:0] Ip_data_async,
  input  logic [15:0] waveform_data_async,
  input  logic        cycle_boundary,
  input  logic        core_idle,
  output logic        run_enable,
  output logic [15:0] Ton_active,
  output logic [15:0] Toff_active,
  output logic [15:0] Ip_active,
  output logic [15:0] waveform_active,
  output logic        params_update,
  output logic        pending,
  output logic        param_reject,
  output logic        drain_fault,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DRAIN   = 2'd2,
    RESTART = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        run_en_d;
  logic        commit;
  logic        fault_d;
  logic [15:0] drain_cnt;

  logic [15:0] ton_sh, toff_sh, ip_sh, wave_sh;
  logic        pend_ton, pend_toff, pend_ip, pend_wave;

  logic start_req, stop_req;
  logic ton_ok, toff_ok, ip_ok;
  logic ton_cap, toff_cap, ip_cap, wave_cap;
  logic reject_d;

  assign start_req = machine_start_ack_spi | machine_start_ack_key;
  assign stop_req  = machine_stop_ack_spi | machine_stop_ack_key;

  assign ton_ok  = (Ton_data_async >= TON_MIN) && (Ton_data_async <= TON_MAX);
  assign toff_ok = (Toff_data_async >= TOFF_MIN);
  assign ip_ok   = (Ip_data_async != 16'd0) && (Ip_data_async <= IP_MAX);

  assign ton_cap  = change_Ton_ack & ton_ok;
  assign toff_cap = change_Toff_ack & toff_ok;
  assign ip_cap   = change_Ip_ack & ip_ok;
  assign wave_cap = change_waveform_ack;

  // Several illegal acks in one cycle still give a single reject pulse.
  assign reject_d = (change_Ton_ack & ~ton_ok) | (change_Toff_ack & ~toff_ok) |
                    (change_Ip_ack & ~ip_ok);

  assign pending = pend_ton | pend_toff | pend_ip | pend_wave;
  assign state   = state_q;

  always_comb begin
    state_d  = state_q;
    run_en_d = run_enable;
    commit   = 1'b0;
    fault_d  = 1'b0;
    case (state_q)
      IDLE: begin
        commit = pending;
        if (stop_req) begin
          run_en_d = 1'b0;
        end else if (start_req) begin
          state_d  = RUN;
          run_en_d = 1'b1;
        end
      end
      RUN: begin
        commit = cycle_boundary & ~pend_wave & pending;
        if (stop_req) begin
          state_d  = IDLE;
          run_en_d = 1'b0;
        end else if (pend_wave) begin
          state_d  = DRAIN;
          run_en_d = 1'b0;
        end
      end
      DRAIN: begin
        if (stop_req) begin
          state_d  = IDLE;
          run_en_d = 1'b0;
        end else if (core_idle) begin
          commit  = 1'b1;
          state_d = RESTART;
        end else if (drain_cnt == DRAIN_TIMEOUT - 16'd1) begin
          state_d = IDLE;
          fault_d = 1'b1;
        end
      end
      RESTART: begin
        if (stop_req) begin
          state_d  = IDLE;
          run_en_d = 1'b0;
        end else begin
          state_d  = RUN;
          run_en_d = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        run_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      run_enable      <= 1'b0;
      params_update   <= 1'b0;
      param_reject    <= 1'b0;
      drain_fault     <= 1'b0;
      drain_cnt       <= 16'd0;
      Ton_active      <= DEF_TON;
      Toff_active     <= DEF_TOFF;
      Ip_active       <= DEF_IP;
      waveform_active <= DEF_WAVE;
      ton_sh          <= DEF_TON;
      toff_sh         <= DEF_TOFF;
      ip_sh           <= DEF_IP;
      wave_sh         <= DEF_WAVE;
      pend_ton        <= 1'b0;
      pend_toff       <= 1'b0;
      pend_ip         <= 1'b0;
      pend_wave       <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_enable    <= run_en_d;
      params_update <= commit;
      param_reject  <= reject_d;
      drain_fault   <= fault_d;
      drain_cnt     <= (state_q == DRAIN) ? drain_cnt + 16'd1 : 16'd0;

      if (commit) begin
        if (pend_ton)  Ton_active      <= ton_sh;
        if (pend_toff) Toff_active     <= toff_sh;
        if (pend_ip)   Ip_active       <= ip_sh;
        if (pend_wave) waveform_active <= wave_sh;
      end

      // A fresh ack in the commit cycle wins over the clear, so it stays pending.
      if (ton_cap) begin
        ton_sh   <= Ton_data_async;
        pend_ton <= 1'b1;
      end else if (commit) begin
        pend_ton <= 1'b0;
      end
      if (toff_cap) begin
        toff_sh   <= Toff_data_async;
        pend_toff <= 1'b1;
      end else if (commit) begin
        pend_toff <= 1'b0;
      end
      if (ip_cap) begin
        ip_sh   <= Ip_data_async;
        pend_ip <= 1'b1;
      end else if (commit) begin
        pend_ip <= 1'b0;
      end
      if (wave_cap) begin
        wave_sh   <= waveform_data_async;
        pend_wave <= 1'b1;
      end else if (commit) begin
        pend_wave <= 1'b0;
      end
    end
  end

endmodule
